uart_rx_param: RTL
==================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter BAUD_MAX, default 52, meaning s_clk cycles per bit; legal range 4..65535.
REQ-002 SHALL have parameter BAUD_MID, default 26, meaning the in-bit count at which the line is sampled; legal range 1..BAUD_MAX-2.
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal range 5..9.
REQ-004 SHALL have parameter PARITY_MODE, default 0, meaning 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame; legal values 1 or 2.
REQ-006 SHALL have port s_clk, input, 1 bit, the single clock; all logic rising-edge.
REQ-007 SHALL have port s_rstn, input, 1 bit, reset, synchronous, active-low.
REQ-008 SHALL have port rs232_rx, input, 1 bit, asynchronous serial line, idle high.
REQ-009 SHALL have port rx_data, output, DATA_BITS bits, last received word, LSB first on the line.
REQ-010 SHALL have port rx_valid, output, 1 bit, one-cycle pulse when a frame completes.
REQ-011 SHALL have port parity_err, output, 1 bit, parity check result, qualified by rx_valid.
REQ-012 SHALL have port frame_err, output, 1 bit, stop-bit check result, qualified by rx_valid.
REQ-013 SHALL have port busy, output, 1 bit, high whenever the FSM is not in IDLE.

Function
REQ-014 SHALL pass rs232_rx through a 2-flop synchronizer, then a third register used for falling-edge detection.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-016 SHALL use a bit-time counter running 0..BAUD_MAX-1 that wraps to 0 and is cleared on entry to START.
REQ-017 SHALL move from IDLE to START on a synchronized falling edge.
REQ-018 SHALL, in START, sample the line at count BAUD_MID; a high sample returns to IDLE (glitch reject) with no output pulse.
REQ-019 SHALL, in START, enter DATA at the counter wrap when the start sample was low.
REQ-020 SHALL, in DATA, sample one bit per bit time at BAUD_MID, shifting LSB first, for DATA_BITS bits.
REQ-021 SHALL, after the last data bit, enter PARITY if PARITY_MODE is nonzero, otherwise STOP.
REQ-022 SHALL, in PARITY, sample one bit and set the internal parity error if the XOR of data and parity bit is 0 for odd or 1 for even.
REQ-023 SHALL, in STOP, sample STOP_BITS bits at BAUD_MID; any low sample sets the internal frame error.
REQ-024 SHALL assert rx_valid for exactly one cycle, in the cycle after the BAUD_MID sample of the final stop bit.
REQ-025 SHALL, in that same cycle, update rx_data, parity_err and frame_err, and return to IDLE.
REQ-026 SHALL leave rx_data, parity_err and frame_err unchanged between rx_valid pulses.
REQ-027 SHALL arm edge detection immediately on return to IDLE, giving the half-bit slack needed for back-to-back frames.
REQ-028 SHALL hold parity_err at 0 when PARITY_MODE is 0.
REQ-029 SHALL still produce rx_valid with the shifted data when a frame error occurs (no frame drop).
REQ-030 SHALL have an end-to-end latency of 3 cycles (synchronizer plus edge register) plus line timing.

Reset
REQ-031 SHALL, while s_rstn is low at a clock edge, set the FSM to IDLE and the counter, shift register, rx_data, rx_valid, parity_err, frame_err and busy to 0, and the synchronizer flops to 1.
REQ-032 SHALL, on reset asserted mid-frame, abandon the frame with no rx_valid; reception resumes on the next falling edge after reset release.

Verification (BAUD_MAX=52, BAUD_MID=26, 1040 ns bit time at a 20 ns clock)
REQ-033 SHALL be checked with 8N1 byte 0x55 -> exactly one rx_valid pulse, rx_data=0x55, parity_err=0, frame_err=0.
REQ-034 SHALL be checked with PARITY_MODE=2, byte 0xA3 sent with parity bit 1 (wrong) -> rx_valid, rx_data=0xA3, parity_err=1; the same byte with parity 0 -> parity_err=0.
REQ-035 SHALL be checked with 8N1 byte 0x3C whose stop bit is driven low -> rx_valid, rx_data=0x3C, frame_err=1.
REQ-036 SHALL be checked with a 10-cycle low glitch on an idle line -> no rx_valid, busy returns low within BAUD_MID+4 cycles.
REQ-037 SHALL be checked with reset pulsed during bit 4 of 0xFF, followed by byte 0x12 -> no pulse for 0xFF, one pulse with rx_data=0x12.
REQ-038 SHALL be checked with 10 back-to-back bytes 0x00..0x09 and no idle gap -> 10 pulses in order, all error flags 0.

Source files
------------

// File: rtl/uart_rx_param.sv
// uart_rx_param: parameterised UART receiver.
// Line -> 2-flop synchronizer -> edge register -> FSM that samples mid-bit.
// Frame results are published with a one-cycle rx_valid pulse and held until the next frame.
module uart_rx_param #(
  parameter int BAUD_MAX    = 52,  // s_clk cycles per bit
  parameter int BAUD_MID    = 26,  // in-bit count at which the line is sampled
  parameter int DATA_BITS   = 8,   // 5..9
  parameter int PARITY_MODE = 0,   // 0 none, 1 odd, 2 even
  parameter int STOP_BITS   = 1    // 1 or 2
) (
  input  logic                 s_clk,
  input  logic                 s_rstn,
  input  logic                 rs232_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(BAUD_MAX);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [3:0]             bit_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   perr_q, ferr_q;
  logic                   sync1_q, sync2_q, edge_q;

  logic fall, mid, wrap, par_x, par_bad, last_data, last_stop;

  // sync2_q is the current line level, edge_q its value one cycle earlier.
  assign fall      = edge_q & ~sync2_q;
  assign mid       = (cnt_q == CW'(BAUD_MID));
  assign wrap      = (cnt_q == CW'(BAUD_MAX - 1));
  assign cnt_d     = wrap ? '0 : cnt_q + 1'b1;
  assign last_data = (bit_q == 4'(DATA_BITS - 1));
  assign last_stop = (bit_q == 4'(STOP_BITS - 1));
  // XOR over the data word and the received parity bit.
  assign par_x     = (^shift_q) ^ sync2_q;
  assign par_bad   = (PARITY_MODE == 1) ? ~par_x : par_x;

  // Metastability synchronizer plus the delayed copy used for falling-edge detection.
  always_ff @(posedge s_clk) begin
    if (!s_rstn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      edge_q  <= 1'b1;
    end else begin
      sync1_q <= rs232_rx;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  // Receive FSM: counter, shift register and registered frame outputs.
  always_ff @(posedge s_clk) begin
    if (!s_rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (fall) begin
            state_q <= START;
            busy    <= 1'b1;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
          end
        end
        START: begin
          cnt_q <= cnt_d;
          if (mid && sync2_q) begin
            // Line went back high before mid-bit: treat as a glitch.
            state_q <= IDLE;
            busy    <= 1'b0;
          end else if (wrap) begin
            state_q <= DATA;
            bit_q   <= '0;
          end
        end
        DATA: begin
          cnt_q <= cnt_d;
          if (mid) shift_q <= {sync2_q, shift_q[DATA_BITS-1:1]};
          if (wrap) begin
            bit_q <= bit_q + 1'b1;
            if (last_data) begin
              state_q <= (PARITY_MODE != 0) ? PARITY : STOP;
              bit_q   <= '0;
            end
          end
        end
        PARITY: begin
          cnt_q <= cnt_d;
          if (mid) perr_q <= par_bad;
          if (wrap) state_q <= STOP;
        end
        STOP: begin
          cnt_q <= cnt_d;
          if (mid) begin
            if (!sync2_q) ferr_q <= 1'b1;
            if (last_stop) begin
              // Publish at the final stop sample; IDLE re-arms with half a bit to spare.
              state_q    <= IDLE;
              busy       <= 1'b0;
              rx_valid   <= 1'b1;
              rx_data    <= shift_q;
              parity_err <= (PARITY_MODE != 0) ? perr_q : 1'b0;
              frame_err  <= ferr_q | ~sync2_q;
            end
          end
          if (wrap) bit_q <= bit_q + 1'b1;
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
